// File: rtl/deck_dealer_pkg.sv
// Shared types for the blackjack card dealer: deck constants,
// dealer state encoding and the decoded card bundle.
package blackjack_pkg;

    localparam int DECK_SIZE      = 52;
    localparam int RANKS_PER_SUIT = 13;
    localparam int IDX_WIDTH      = 6;
    localparam int CNT_WIDTH      = $clog2(DECK_SIZE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_PROBE
    } dealer_state_e;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] index;
        logic [3:0]           rank;
        logic [1:0]           suit;
        logic [3:0]           points;
    } card_t;

    // Next probe candidate, wrapping the last card back to index 0.
    function automatic logic [IDX_WIDTH-1:0] next_idx(
        input logic [IDX_WIDTH-1:0] idx
    );
        if (idx == IDX_WIDTH'(DECK_SIZE - 1))
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/deck_dealer_if.sv
// Random-number handshake between the dealer (master) and the
// random number generator (slave).
interface deck_dealer_if;
    import blackjack_pkg::*;

    logic                 o_rng_request;
    logic [IDX_WIDTH-1:0] o_rng_max;
    logic [IDX_WIDTH-1:0] i_rng_value;

    modport master (
        output o_rng_request,
        output o_rng_max,
        input  i_rng_value
    );

    modport slave (
        input  o_rng_request,
        input  o_rng_max,
        output i_rng_value
    );

endinterface

// File: rtl/counter.sv
// Loadable down-counter with synchronous active-low reset;
// load takes priority over decrement.
module counter #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: reload beats decrement.
    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec)
            count_d = count_q - 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/deck_dealer_card_decode.sv
// Combinational card index decoder: index -> rank, suit, points.
// Shared with the display logic.
module card_decode
    import blackjack_pkg::*;
(
    input  logic [IDX_WIDTH-1:0] idx,
    output card_t                card
);

    localparam logic [IDX_WIDTH-1:0] RPS = IDX_WIDTH'(RANKS_PER_SUIT);

    // Suit is the quotient, rank the 1-based remainder; faces score 10.
    always_comb begin
        card        = '0;
        card.index  = idx;
        card.suit   = 2'(idx / RPS);
        card.rank   = 4'(idx % RPS) + 4'd1;
        card.points = (card.rank > 4'd10) ? 4'd10 : card.rank;
    end

endmodule

// File: rtl/deck_dealer.sv
// Card dealer: requests a random index, probes past dealt cards.
// Optional DEALER_AUTO_SHUFFLE_EN: deal on empty deck reshuffles.
module deck_dealer
    import blackjack_pkg::*;
#(
    parameter int DECK_SIZE = 52,
    parameter int IDX_WIDTH = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_deal,
    input  logic                 i_shuffle,
    deck_dealer_if.master        rng,
    output logic                 o_busy,
    output logic                 o_card_valid,
    output logic [IDX_WIDTH-1:0] o_card_index,
    output logic [3:0]           o_card_rank,
    output logic [1:0]           o_card_suit,
    output logic [3:0]           o_card_points,
    output logic                 o_deck_empty,
    output logic                 o_deal_error
);

    localparam logic [IDX_WIDTH-1:0] DS_IDX = IDX_WIDTH'(DECK_SIZE);
    localparam logic [CNT_WIDTH-1:0] DS_CNT = CNT_WIDTH'(DECK_SIZE);

    dealer_state_e          state_q, state_d;
    logic [DECK_SIZE-1:0]   mask_q, mask_d;
    logic [IDX_WIDTH-1:0]   cand_q, cand_d;
    card_t                  card_q, card_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   req_q, req_d;
    logic                   empty_q, empty_d;

    logic                   cnt_load;
    logic                   cnt_dec;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [IDX_WIDTH-1:0]   rng_idx;
    logic [IDX_WIDTH-1:0]   test_idx;
    card_t                  card_dec;

    counter #(
        .WIDTH   (CNT_WIDTH),
        .RST_VAL (DS_CNT)
    ) u_remaining (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (DS_CNT),
        .dec      (cnt_dec),
        .count    (remaining)
    );

    card_decode u_decode (
        .idx  (test_idx),
        .card (card_dec)
    );

    // Fold the RNG value into range and pick the candidate to test.
    always_comb begin
        rng_idx = rng.i_rng_value;
        if (rng.i_rng_value >= DS_IDX)
            rng_idx = rng.i_rng_value - DS_IDX;
        test_idx = (state_q == ST_CHECK) ? rng_idx : cand_q;
    end

    // Dealer next-state and output decisions.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cand_d   = cand_q;
        card_d   = card_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        req_d    = 1'b0;
        empty_d  = (remaining == '0);
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_shuffle) begin
                    mask_d   = '0;
                    cnt_load = 1'b1;
                end else if (i_deal) begin
                    if (remaining != '0) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end else begin
`ifdef DEALER_AUTO_SHUFFLE_EN
                        mask_d   = '0;
                        cnt_load = 1'b1;
                        state_d  = ST_REQ;
                        req_d    = 1'b1;
`else
                        err_d = 1'b1;
`endif
                    end
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: state_d = ST_CHECK;
            ST_CHECK, ST_PROBE: begin
                if (!mask_q[test_idx]) begin
                    mask_d[test_idx] = 1'b1;
                    card_d  = card_dec;
                    valid_d = 1'b1;
                    cnt_dec = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cand_d  = next_idx(test_idx);
                    state_d = ST_PROBE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dealer state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cand_q  <= '0;
            card_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cand_q  <= cand_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            req_q   <= req_d;
            empty_q <= empty_d;
        end
    end

    assign rng.o_rng_request = req_q;
    assign rng.o_rng_max     = IDX_WIDTH'(DECK_SIZE - 1);
    assign o_busy            = (state_q != ST_IDLE);
    assign o_card_valid      = valid_q;
    assign o_card_index      = card_q.index;
    assign o_card_rank       = card_q.rank;
    assign o_card_suit       = card_q.suit;
    assign o_card_points     = card_q.points;
    assign o_deck_empty      = empty_q;
    assign o_deal_error      = err_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer with a card scoreboard and a
// reference dealt-mask model.
module tb_deck_dealer;
    import blackjack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       deal = 1'b0;
    logic       shuffle = 1'b0;
    logic       busy, cv, empty, derr;
    logic [5:0] cidx;
    logic [3:0] crank, cpts;
    logic [1:0] csuit;

    deck_dealer_if rng_if ();

    deck_dealer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_deal        (deal),
        .i_shuffle     (shuffle),
        .rng           (rng_if),
        .o_busy        (busy),
        .o_card_valid  (cv),
        .o_card_index  (cidx),
        .o_card_rank   (crank),
        .o_card_suit   (csuit),
        .o_card_points (cpts),
        .o_deck_empty  (empty),
        .o_deal_error  (derr)
    );

    always #5 clk = ~clk;

    int        total = 0;
    int        bad = 0;
    bit [51:0] m = '0;
    card_t     sb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic card_t ref_card(input int idx);
        card_t c;
        int    s, r;
        s = 0;
        r = idx;
        while (r >= 13) begin
            r = r - 13;
            s++;
        end
        c.index  = 6'(idx);
        c.suit   = 2'(s);
        c.rank   = 4'(r + 1);
        c.points = (r + 1 > 10) ? 4'd10 : 4'(r + 1);
        return c;
    endfunction

    task automatic deal_card(input int rv, input bit hold);
        int    c, p, lat, reqs;
        bit    got;
        card_t exp;
        c = (rv >= 52) ? rv - 52 : rv;
`ifdef DEALER_AUTO_SHUFFLE_EN
        if (&m) m = '0;
`endif
        p = 0;
        while (m[c]) begin
            c = (c == 51) ? 0 : c + 1;
            p++;
        end
        m[c] = 1'b1;
        sb.push_back(ref_card(c));
        @(negedge clk);
        rng_if.i_rng_value = 6'(rv);
        deal = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) deal = 1'b0;
        reqs = int'(rng_if.o_rng_request);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
            if (rng_if.o_rng_request) reqs++;
            if (cv) got = 1'b1;
        end
        deal = 1'b0;
        check("valid_seen", 32'(got), 1);
        check("latency", lat, 3 + p);
        check("req_pulses", reqs, 1);
        check("busy_at_valid", 32'(busy), 0);
        exp = sb.pop_front();
        if (got) begin
            check("card_index", 32'(cidx), 32'(exp.index));
            check("card_rank", 32'(crank), 32'(exp.rank));
            check("card_suit", 32'(csuit), 32'(exp.suit));
            check("card_points", 32'(cpts), 32'(exp.points));
        end
    endtask

    task automatic do_shuffle();
        @(negedge clk);
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        m = '0;
        check("shuffle_busy", 32'(busy), 0);
    endtask

    initial begin
        rng_if.i_rng_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(cv), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(rng_if.o_rng_request), 0);
        check("rst_max", 32'(rng_if.o_rng_max), 51);
        check("rst_empty", 32'(empty), 0);
        check("rst_err", 32'(derr), 0);
        check("rst_index", 32'(cidx), 0);
        check("rst_rank", 32'(crank), 0);
        @(negedge clk);
        rst_n = 1'b1;

        deal_card(0, 1'b0);
        check("first_rank", 32'(crank), 1);

        deal_card(24, 1'b0);
        check("q_rank", 32'(crank), 12);
        check("q_suit", 32'(csuit), 1);
        check("q_points", 32'(cpts), 10);

        deal_card(24, 1'b0);
        check("probe_index", 32'(cidx), 25);

        deal_card(7, 1'b1);
        @(posedge clk);
        #1;
        check("held_deal_busy", 32'(busy), 0);
        check("held_deal_valid", 32'(cv), 0);

        @(negedge clk);
        deal = 1'b1;
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        deal = 1'b0;
        shuffle = 1'b0;
        m = '0;
        check("both_busy", 32'(busy), 0);
        check("both_req", 32'(rng_if.o_rng_request), 0);
        @(posedge clk);
        #1;
        check("both_busy2", 32'(busy), 0);
        deal_card(0, 1'b0);
        check("after_shuf_idx", 32'(cidx), 0);

        do_shuffle();
        deal_card(51, 1'b0);
        for (int k = 0; k < 50; k++) deal_card(k, 1'b0);
        check("fill_not_empty", 32'(empty), 0);
        deal_card(51, 1'b0);
        check("wrap_index", 32'(cidx), 50);
        check("empty_same_cycle", 32'(empty), 0);
        @(posedge clk);
        #1;
        check("empty_next", 32'(empty), 1);

`ifdef DEALER_AUTO_SHUFFLE_EN
        deal_card(9, 1'b0);
        check("auto_index", 32'(cidx), 9);
        check("auto_err", 32'(derr), 0);
        @(posedge clk);
        #1;
        check("auto_empty", 32'(empty), 0);
`else
        @(negedge clk);
        deal = 1'b1;
        @(posedge clk);
        #1;
        deal = 1'b0;
        check("err_pulse", 32'(derr), 1);
        check("err_busy", 32'(busy), 0);
        check("err_req", 32'(rng_if.o_rng_request), 0);
        @(posedge clk);
        #1;
        check("err_drop", 32'(derr), 0);
        check("err_empty", 32'(empty), 1);
`endif

        do_shuffle();
        deal_card(0, 1'b0);
        deal_card(1, 1'b0);
        deal_card(2, 1'b0);
        @(negedge clk);
        rng_if.i_rng_value = 6'd0;
        deal = 1'b1;
        @(posedge clk);
        #1;
        deal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("probe_busy", 32'(busy), 1);
        check("probe_novalid", 32'(cv), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(cv), 0);
        check("abort_empty", 32'(empty), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m = '0;
        @(posedge clk);
        #1;
        check("abort_valid2", 32'(cv), 0);
        deal_card(63, 1'b0);
        check("fold_index", 32'(cidx), 11);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deck_dealer.md
# deck_dealer

Requester side of the random-number handshake: on a deal command from the game FSM, pulses the random number generator, samples its value as a card index (0..51), resolves collisions with already-dealt cards by linear probing, and returns a decoded card. Keeps a 52-bit dealt mask so no card repeats until a shuffle. Sits between the game control FSM and `randomNumberGenerator`.

## Interface
- `DECK_SIZE`, default 52: cards per deck; index range 0..DECK_SIZE-1.
- `IDX_WIDTH`, default 6: card index width; must satisfy 2^IDX_WIDTH ≥ DECK_SIZE.

Ports:
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_deal`  in  1  deal request; sampled only in IDLE.
- `i_shuffle`  in  1  clear dealt mask; sampled only in IDLE.
- `o_rng_request`  out  1  request pulse to RNG (RNG captures on its rising edge).
- `o_rng_max`  out  IDX_WIDTH  constant DECK_SIZE-1 (51).
- `i_rng_value`  in  IDX_WIDTH  RNG output.
- `o_busy`  out  1  high in every state except IDLE.
- `o_card_valid`  out  1  one-cycle pulse; card outputs valid this cycle and held until next deal.
- `o_card_index`  out  IDX_WIDTH  dealt index.
- `o_card_rank`  out  4  1..13 (A=1, J=11, Q=12, K=13).
- `o_card_suit`  out  2  index / 13.
- `o_card_points`  out  4  A=1, 2..10 face, J/Q/K=10.
- `o_deck_empty`  out  1  all DECK_SIZE cards dealt.
- `o_deal_error`  out  1  one-cycle pulse: deal requested while deck empty.

## Operation
- States: IDLE, REQ, WAIT, CHECK, PROBE.
- IDLE: `i_shuffle` has priority: clears mask and remaining count in one cycle, stays IDLE. Else `i_deal` with deck non-empty → REQ; with deck empty → `o_deal_error` pulse, stay IDLE.
- REQ: `o_rng_request`=1 for exactly one cycle → WAIT.
- WAIT: request low; RNG value settles → CHECK.
- CHECK: sample `i_rng_value`; if ≥ DECK_SIZE, subtract DECK_SIZE. If mask bit clear → set bit, register card, pulse `o_card_valid`, decrement remaining, → IDLE. If set → PROBE with candidate+1.
- PROBE: one candidate per cycle, wrap DECK_SIZE-1 → 0; first clear bit handled as in CHECK. Non-empty deck guarantees termination within DECK_SIZE-1 probes.
- `i_deal`/`i_shuffle` ignored while busy; not queued.
- Rank/suit/points decoded from index: suit = idx/13, rank = idx%13 + 1, points = min(rank,10).

## Timing
- Reset (`i_rst_n`=0 at edge): state IDLE, mask cleared, remaining=DECK_SIZE; all outputs 0 except `o_rng_max`=51. Reset mid-deal aborts; no card emitted.
- Latency deal-accept to `o_card_valid`: 3 cycles with no collision, +1 per probe; worst case 3+51.
- `o_deck_empty` updates the cycle after the last card's `o_card_valid`.

## Configuration
- `DEALER_AUTO_SHUFFLE_EN`: if defined, deal while deck empty clears mask and proceeds to REQ in the same IDLE cycle (no `o_deal_error`; one card then dealt from a fresh deck). If undefined, behaviour as above (error pulse, no deal).

## Structure
- `blackjack_pkg`: `DECK_SIZE`, `RANKS_PER_SUIT`=13, dealer state enum, `card_t` struct {index, rank, suit, points}.
- Sub-module `card_decode`: combinational index → rank/suit/points; reused by display logic.
- Remaining-card count uses the existing `counter` module.

## Test plan
- Reset then deal with RNG=0 → `o_card_valid` 3 cycles after accept, index 0, rank 1, suit 0, points 1.
- Deal RNG=24 → rank 12, suit 1, points 10; deal again RNG=24 → index 25 after 4 cycles (one probe).
- Mask holds 51 dealt, only 50 free, RNG=51 → wraps 51→0→…→50, valid at cycle 3+51.
- 52 deals then deal: `o_deck_empty`=1, `o_deal_error` pulse (auto-shuffle undefined); with `DEALER_AUTO_SHUFFLE_EN`, card dealt and `o_deck_empty` drops.
- `i_deal` and `i_shuffle` same IDLE cycle → shuffle only, `o_busy` stays 0; `i_deal` during WAIT ignored.
- `i_rst_n` low during PROBE → IDLE next cycle, no `o_card_valid`, mask cleared, RNG=63 on next deal → index 11.
